// File: rtl/lsu_pkg.sv
// Shared encodings and alignment helpers for the load/store unit.
// Consumed by load_store_unit and lsu_lane_align via import lsu_pkg::*.
package lsu_pkg;

    localparam int ADDR_W = 7;
    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // A reserved size is never a legal access, whatever the address.
    function automatic logic misaligned(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] align_addr(input size_e size, input logic [ADDR_W-1:0] addr);
        case (size)
            SZ_HALF: return {addr[ADDR_W-1:1], 1'b0};
            SZ_WORD: return {addr[ADDR_W-1:2], 2'b00};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane(s) of a captured word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] load_word,
    input  logic [WORD_W-1:0] store_base,
    input  logic [WORD_W-1:0] store_data,
    input  size_e             size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [BYTE_W-1:0] load_byte;
    logic [HALF_W-1:0] load_half;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        load_byte  = load_word[{offset, 3'b000} +: BYTE_W];
        load_half  = load_word[{offset[1], 4'b0000} +: HALF_W];
        load_data  = load_word;
        store_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_data  = {{(WORD_W-BYTE_W){~is_unsigned & load_byte[BYTE_W-1]}}, load_byte};
                store_word = store_base;
                store_word[{offset, 3'b000} +: BYTE_W] = store_data[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data  = {{(WORD_W-HALF_W){~is_unsigned & load_half[HALF_W-1]}}, load_half};
                store_word = store_base;
                store_word[{offset[1], 4'b0000} +: HALF_W] = store_data[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding CPU requests to a word-addressed memory,
// with read-modify-write for sub-word stores. Optional macro LSU_ALIGN_CHECK_EN
// turns misaligned/reserved requests into error responses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] WriteData,
    input  logic [WORD_W-1:0] ReadData
);

    state_e            state;
    logic              write_q;
    logic              unsigned_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rd_word;
    logic              mem_read_q;
    logic              mem_write_q;

    size_e             eff_size;
    logic [ADDR_W-1:0] eff_addr;
    logic              req_bad;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merge_word;

    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        eff_size = size_e'(req_size);
        eff_addr = req_addr;
        req_bad  = misaligned(size_e'(req_size), req_addr[1:0]);
`else
        eff_size = (size_e'(req_size) == SZ_RSVD) ? SZ_WORD : size_e'(req_size);
        eff_addr = align_addr(eff_size, req_addr);
        req_bad  = 1'b0;
`endif
    end

    lsu_lane_align u_lane_align (
        .load_word   (ReadData),
        .store_base  (rd_word),
        .store_data  (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .store_word  (merge_word)
    );

    // NOTE: the reset is synchronous, so the strobes are also gated by reset_n
    // combinationally; otherwise a reset during RD/WR would still hit memory.
    assign MemRead     = mem_read_q & reset_n;
    assign MemWrite    = mem_write_q & reset_n;
    assign mem_address = {addr_q[ADDR_W-1:2], 2'b00};
    assign WriteData   = (state == WR) ? merge_word : '0;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_word     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= eff_size;
                        addr_q     <= eff_addr;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_write && eff_size == SZ_WORD) begin
                            state       <= WR;
                            mem_write_q <= 1'b1;
                        end else begin
                            state      <= RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_read_q <= 1'b0;
                    rd_word    <= ReadData;
                    if (write_q) begin
                        state       <= WR;
                        mem_write_q <= 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                    end
                end
                WR: begin
                    mem_write_q <= 1'b0;
                    state       <= RESP;
                    rsp_valid   <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural data
// memory and a response scoreboard; honours LSU_ALIGN_CHECK_EN when defined.
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [6:0]  mem_address;
    logic [31:0] WriteData;
    logic [31:0] ReadData = '0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;

    logic [31:0] mem[32];
    logic        pl_en  = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    logic        obs_rd1, obs_wr1, obs_wr2, saw_rd;
    logic [6:0]  obs_addr1;
    logic [31:0] obs_wd1, obs_wd2;
    int          obs_lat;

    load_store_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_address  (mem_address),
        .WriteData    (WriteData),
        .ReadData     (ReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: reads sampled mid-cycle, writes on the closing posedge.
    always @(negedge clock) if (MemRead) ReadData <= mem[mem_address[6:2]];
    always @(posedge clock) begin
        if (MemWrite) mem[mem_address[6:2]] <= WriteData;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("mem_rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [6:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n;
        @(negedge clock);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        check("ready_at_accept", {31'b0, req_ready}, 32'h1);
        sb.push_back({er, ee});
        saw_rd = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            req_valid = 1'b0;
            if (n == 1) begin
                obs_rd1 = MemRead; obs_wr1 = MemWrite; obs_addr1 = mem_address; obs_wd1 = WriteData;
            end
            if (n == 2) begin
                obs_wr2 = MemWrite; obs_wd2 = WriteData;
            end
            saw_rd |= MemRead;
        end while (!rsp_valid && n < 8);
        obs_lat = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pl_vals [4];
        pl_vals = '{32'h00000003, 32'h80FF7F01, 32'h11223344, 32'h01234567};
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Preload words 0x04..0x10 while reset is held.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pl_en = 1'b1; pl_idx = 5'(i + 1); pl_data = pl_vals[i];
        end
        @(negedge clock);
        pl_en = 1'b0;
        @(negedge clock);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("reset_mem_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
        check("reset_mem_address", {25'b0, mem_address}, 32'h0);
        check("reset_write_data", WriteData, 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Word load.
        do_req(1'b0, 2'b10, 1'b0, 7'h04, 32'h0, 32'h00000003, 1'b0);
        check("lw_latency", obs_lat, 2);
        check("lw_memread_c1", {31'b0, obs_rd1}, 32'h1);
        check("lw_addr_c1", {25'b0, obs_addr1}, 32'h04);
        check("lw_no_write_c1", {31'b0, obs_wr1}, 32'h0);

        // Byte loads, signed and unsigned.
        do_req(1'b0, 2'b00, 1'b0, 7'h0A, 32'h0, 32'hFFFFFFFF, 1'b0);
        check("lb_0a_latency", obs_lat, 2);
        do_req(1'b0, 2'b00, 1'b1, 7'h0A, 32'h0, 32'h000000FF, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 7'h0B, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 7'h08, 32'h0, 32'h00000001, 1'b0);
        check("lb_08_addr", {25'b0, obs_addr1}, 32'h08);

        // Half store: read-modify-write of the upper lane.
        do_req(1'b1, 2'b01, 1'b0, 7'h0E, 32'h0000ABCD, 32'h0, 1'b0);
        check("sh_latency", obs_lat, 3);
        check("sh_read_c1", {31'b0, obs_rd1}, 32'h1);
        check("sh_addr_c1", {25'b0, obs_addr1}, 32'h0C);
        check("sh_write_c2", {31'b0, obs_wr2}, 32'h1);
        check("sh_wdata_c2", obs_wd2, 32'hABCD3344);
        check("sh_mem", mem[3], 32'hABCD3344);

        // Half loads of the stored word.
        do_req(1'b0, 2'b01, 1'b0, 7'h0E, 32'h0, 32'hFFFFABCD, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 7'h0C, 32'h0, 32'h00003344, 1'b0);

        // Byte store into lane 1, then read the whole word back.
        do_req(1'b1, 2'b00, 1'b0, 7'h09, 32'h00000055, 32'h0, 1'b0);
        check("sb_latency", obs_lat, 3);
        check("sb_wdata_c2", obs_wd2, 32'h80FF5501);
        do_req(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'h80FF5501, 1'b0);

        // Word store goes straight to WR.
        do_req(1'b1, 2'b10, 1'b0, 7'h14, 32'hCAFEF00D, 32'h0, 1'b0);
        check("sw_latency", obs_lat, 2);
        check("sw_no_read_c1", {31'b0, obs_rd1}, 32'h0);
        check("sw_write_c1", {31'b0, obs_wr1}, 32'h1);
        check("sw_wdata_c1", obs_wd1, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 7'h14, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset while a word store sits in WR.
        @(negedge clock);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 7'h10;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        check("rst_wr_memwrite", {31'b0, MemWrite}, 32'h0);
        check("rst_wr_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_wr_ready_after", {31'b0, req_ready}, 32'h1);
        check("rst_wr_rsp_after", {31'b0, rsp_valid}, 32'h0);
        check("rst_wr_mem_unchanged", mem[4], 32'h01234567);
        @(negedge clock);
        check("rst_wr_no_late_rsp", {31'b0, rsp_valid}, 32'h0);

        // Misaligned word load and reserved size.
`ifdef LSU_ALIGN_CHECK_EN
        do_req(1'b0, 2'b10, 1'b0, 7'h05, 32'h0, 32'h0, 1'b1);
        check("lw_misaligned_latency", obs_lat, 1);
        check("lw_misaligned_no_read", {31'b0, saw_rd}, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 7'h04, 32'h0, 32'h0, 1'b1);
        check("rsvd_latency", obs_lat, 1);
        check("rsvd_no_read", {31'b0, saw_rd}, 32'h0);
`else
        do_req(1'b0, 2'b10, 1'b0, 7'h05, 32'h0, 32'h00000003, 1'b0);
        check("lw_misaligned_latency", obs_lat, 2);
        check("lw_misaligned_addr", {25'b0, obs_addr1}, 32'h04);
        do_req(1'b0, 2'b11, 1'b0, 7'h08, 32'h0, 32'h80FF5501, 1'b0);
        check("rsvd_latency", obs_lat, 2);
`endif

        // Back-to-back loads with req_valid held through the busy cycles.
        @(negedge clock);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 7'h04;
        req_valid = 1'b1;
        check("b2b_ready_c0", {31'b0, req_ready}, 32'h1);
        sb.push_back({32'h00000003, 1'b0});
        @(negedge clock);
        check("b2b_ready_c1", {31'b0, req_ready}, 32'h0);
        req_size = 2'b00; req_addr = 7'h08;
        sb.push_back({32'h00000001, 1'b0});
        @(negedge clock);
        check("b2b_ready_c2", {31'b0, req_ready}, 32'h0);
        check("b2b_rsp1_c2", {31'b0, rsp_valid}, 32'h1);
        @(negedge clock);
        check("b2b_ready_c3", {31'b0, req_ready}, 32'h1);
        @(negedge clock);
        req_valid = 1'b0;
        check("b2b_ready_c4", {31'b0, req_ready}, 32'h0);
        check("b2b_read_c4", {31'b0, MemRead}, 32'h1);
        check("b2b_addr_c4", {25'b0, mem_address}, 32'h08);
        @(negedge clock);
        check("b2b_rsp2_c5", {31'b0, rsp_valid}, 32'h1);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  in  1  CPU request present; req_ready  out  1  unit can accept a request.
REQ-004 SHALL have ports: req_write  in  1  1=store, 0=load; req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-005 SHALL have ports: req_unsigned  in  1  zero-extend loads; req_addr  in  7  byte address; req_wdata  in  32  store data, right-aligned.
REQ-006 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  load result; rsp_err  out  1  misaligned request.
REQ-007 SHALL have memory-side ports: MemRead  out  1; MemWrite  out  1; mem_address  out  7  word-aligned byte address; WriteData  out  32; ReadData  in  32.

Function
REQ-008 SHALL be the initiator for the word-addressed data memory; memory samples MemRead on the mid-cycle negedge and writes on the posedge closing a cycle with MemWrite=1.
REQ-009 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE with req_valid=1, latch write, size, unsigned, addr and wdata; next state: load->RD, word store->WR, byte/half store->RD.
REQ-011 SHALL, in RD, drive MemRead=1, mem_address={addr[6:2],2'b00}, and capture ReadData at the closing posedge; next: load->RESP, store->WR.
REQ-012 SHALL, in WR, drive MemWrite=1 with WriteData = req_wdata (word) or captured word with the addressed lane(s) replaced (byte/half); next RESP.
REQ-013 SHALL, in RESP, drive rsp_valid=1 for exactly one cycle, then return to IDLE; no response backpressure.
REQ-014 SHALL use little-endian lanes: byte lane = addr[1:0] -> bits [8k+7:8k]; halfword lane = addr[1] -> bits [16h+15:16h].
REQ-015 SHALL sign-extend byte/half loads when req_unsigned=0, zero-extend when 1; rsp_rdata is 0 for stores and valid only while rsp_valid=1.
REQ-016 SHALL give latencies (acceptance cycle = 0): load rsp in cycle 2; word store rsp in cycle 2; byte/half store rsp in cycle 3.
REQ-017 SHALL never assert MemRead and MemWrite in the same cycle; both 0 in IDLE and RESP.
REQ-018 SHALL treat req_size=11 as word when LSU_ALIGN_CHECK_EN is undefined.
REQ-019 SHALL ignore req_valid while busy; a request held across busy cycles is accepted in the first IDLE cycle after RESP.

Reset
REQ-020 SHALL, on a posedge with reset_n=0, enter IDLE and clear latched request, captured word, rsp_valid, rsp_rdata, rsp_err.
REQ-021 SHALL force MemRead=0 and MemWrite=0 combinationally whenever reset_n=0, so a reset during RD/WR issues no memory access and produces no response.
REQ-022 SHALL hold reset values: req_ready=1 after reset, all other outputs 0.

Configuration
REQ-023 SHALL support macro LSU_ALIGN_CHECK_EN.
REQ-024 SHALL, when defined, flag half with addr[0]=1, word with addr[1:0]!=0, or size=11 as errors: go IDLE->RESP directly with rsp_err=1, no memory access.
REQ-025 SHALL, when undefined, tie rsp_err=0 and force misaligned addresses down to natural alignment.

Structure
REQ-026 SHALL place size encodings, state encoding and lane-width constants in shared package lsu_pkg.
REQ-027 SHALL isolate lane extract/extend and lane merge in combinational sub-module lsu_lane_align.

Verification
REQ-028 Word load: mem[0x04]=0x00000003, lw 0x04 -> MemRead cycle 1 at 0x04, rsp_valid cycle 2, rsp_rdata=0x00000003.
REQ-029 Byte loads: mem[0x08]=0x80FF7F01; lb 0x0A -> 0xFFFFFFFF; lbu 0x0A -> 0x000000FF; lb 0x0B -> 0xFFFFFF80; lb 0x08 -> 0x00000001.
REQ-030 Half store: mem[0x0C]=0x11223344, sh 0x0E wdata 0x0000ABCD -> RD cycle 1, WR cycle 2 WriteData=0xABCD3344, rsp cycle 3.
REQ-031 Reset mid-op: reset_n=0 during WR of sw 0x10 wdata 0xDEADBEEF -> MemWrite=0 that cycle, mem[0x10] unchanged, no rsp_valid, req_ready=1 next cycle.
REQ-032 Misaligned lw 0x05: macro defined -> no MemRead, rsp_valid cycle 1 with rsp_err=1; undefined -> reads 0x04, rsp_err=0.
REQ-033 Back-to-back: req_valid held with two loads -> req_ready=0 cycles 1-2, second accepted cycle 3, second rsp cycle 5.
